trace_sweep_ctrl: RTL

Sequencer that drives the tracer-programming port of the sensor trace stamper, sweeping a group of tracer cells across the frame. On each start-of-frame it rewrites up to 8 tracer cell indices through the indexed write strobe, then enables them. This lets test software trace a moving cell pattern across many frames without per-frame register writes. It sits between the AXI-Lite config block and the stamper, on the stamper's clock.

---
 rtl/trace_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/trace_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// trace_sweep_ctrl
//
// Purpose:
//   This sequencer drives the tracer-programming port of the sensor trace
//   stamper. Once started, it reprograms up to TRACERS tracer cells on every
//   start-of-frame and then enables them. Tracer 0 advances by cfg_step cells
//   per frame. The other tracers follow tracer 0 at cfg_stride spacing. Every
//   position wraps modulo cfg_cell_limit. Test software can therefore sweep a
//   moving cell pattern across many frames without writing registers on each
//   frame.
//
// Ports:
//   clk                     clock, shared with the stamper
//   resetn                  asynchronous active-low reset
//   cfg_base                cell index of tracer 0 in the first traced frame
//   cfg_stride              cell spacing between consecutive tracers
//   cfg_step                per-frame advance of tracer 0
//   cfg_cell_limit          cells per frame (wrap modulus)
//   cfg_count               tracers used, 1..8 (larger values clamp to 8)
//   cfg_frames              frames to trace, 0 = run until stop
//   start                   pulse: latch cfg_* and begin a run (IDLE only)
//   stop                    pulse: abort the run from any state
//   sof                     stamper start-of-frame
//   tracer_index            slot being written
//   wr_tracer_cell          cell index being written
//   wr_tracer_cell_wstrobe  write strobe for the indexed tracer write
//   tracer_enable           per-slot tracer enable
//   busy                    high whenever the sequencer is not idle
//   frames_done             frames traced in this run (held after stop)
//   overrun                 sticky: an sof arrived while still programming
//   done_irq                (only with TRACE_SWEEP_IRQ_EN) one-cycle pulse
//                           when a run ends because cfg_frames was reached
//
// Build option:
//   TRACE_SWEEP_IRQ_EN  - when defined, adds the done_irq output.
//
// All outputs are registered. On the sof edge the first tracer write (k=0)
// is registered directly, so for N tracers the writes are presented on the
// N cycles after the sof edge. The enable mask follows on the next cycle.
// ---------------------------------------------------------------------------
module trace_sweep_ctrl #(
    parameter int TRACERS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] cfg_base,
    input  logic [31:0] cfg_stride,
    input  logic [31:0] cfg_step,
    input  logic [31:0] cfg_cell_limit,
    input  logic [3:0]  cfg_count,
    input  logic [31:0] cfg_frames,
    input  logic        start,
    input  logic        stop,
    input  logic        sof,
    output logic [2:0]  tracer_index,
    output logic [31:0] wr_tracer_cell,
    output logic        wr_tracer_cell_wstrobe,
    output logic [7:0]  tracer_enable,
    output logic        busy,
    output logic [31:0] frames_done,
    output logic        overrun
`ifdef TRACE_SWEEP_IRQ_EN
    ,
    output logic        done_irq
`endif
);

    localparam logic [3:0] MAX_COUNT = 4'(TRACERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PROG = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t      state_reg;

    // Configuration latched at start; the cfg_* inputs may change mid-run.
    logic [31:0] stride_reg;
    logic [31:0] step_reg;
    logic [31:0] limit_reg;
    logic [31:0] frames_reg;
    logic [3:0]  count_reg;

    logic [31:0] head_reg;   // tracer-0 position for the current frame
    logic [31:0] acc_reg;    // position of the next tracer to write
    logic [3:0]  k_reg;      // index of the next tracer to write

    // Modular add. Both operands are below the limit, so the sum is below
    // 2*limit. A 33-bit sum and a single conditional subtract are enough.
    function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, lim}) begin
            sum = sum - {1'b0, lim};
        end
        return sum[31:0];
    endfunction

    // Clamp the requested tracer count to the number of physical slots.
    logic [3:0] count_clamped;
    assign count_clamped = (cfg_count > MAX_COUNT) ? MAX_COUNT : cfg_count;

    // Enable mask (1 << N) - 1, built one slot at a time.
    logic [7:0] enable_mask;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign enable_mask[gi] = (count_reg > 4'(gi));
        end
    endgenerate

    // Head for the frame about to be programmed. In ARM this is the latched
    // base. In RUN it is the previous head advanced by one step. prog_acc1 is
    // the position of tracer 1 for that frame.
    logic [31:0] next_head;
    logic [31:0] prog_head;
    logic [31:0] prog_acc1;
    logic [31:0] acc_next;

    assign next_head = wrap_add(head_reg, step_reg, limit_reg);
    assign prog_head = (state_reg == ST_RUN) ? next_head : head_reg;
    assign prog_acc1 = wrap_add(prog_head, stride_reg, limit_reg);
    assign acc_next  = wrap_add(acc_reg, stride_reg, limit_reg);

    // A run ends on the sof that follows the final traced frame.
    logic run_complete;
    assign run_complete = (frames_reg != 32'd0) && (frames_done == frames_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg              <= ST_IDLE;
            stride_reg             <= 32'd0;
            step_reg               <= 32'd0;
            limit_reg              <= 32'd0;
            frames_reg             <= 32'd0;
            count_reg              <= 4'd0;
            head_reg               <= 32'd0;
            acc_reg                <= 32'd0;
            k_reg                  <= 4'd0;
            tracer_index           <= 3'd0;
            wr_tracer_cell         <= 32'd0;
            wr_tracer_cell_wstrobe <= 1'b0;
            tracer_enable          <= 8'd0;
            busy                   <= 1'b0;
            frames_done            <= 32'd0;
            overrun                <= 1'b0;
`ifdef TRACE_SWEEP_IRQ_EN
            done_irq               <= 1'b0;
`endif
        end else begin
`ifdef TRACE_SWEEP_IRQ_EN
            done_irq <= 1'b0;
`endif
            if (stop) begin
                // An abort takes priority over sof and start in every state.
                // frames_done keeps its count so software can read it back.
                state_reg              <= ST_IDLE;
                busy                   <= 1'b0;
                tracer_enable          <= 8'd0;
                wr_tracer_cell_wstrobe <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && (cfg_count != 4'd0) && (cfg_cell_limit != 32'd0)) begin
                            stride_reg  <= cfg_stride;
                            step_reg    <= cfg_step;
                            limit_reg   <= cfg_cell_limit;
                            frames_reg  <= cfg_frames;
                            count_reg   <= count_clamped;
                            head_reg    <= cfg_base;
                            frames_done <= 32'd0;
                            overrun     <= 1'b0;
                            busy        <= 1'b1;
                            state_reg   <= ST_ARM;
                        end
                    end

                    ST_ARM: begin
                        if (sof) begin
                            // Register the k=0 write on the sof edge itself.
                            wr_tracer_cell_wstrobe <= 1'b1;
                            tracer_index           <= 3'd0;
                            wr_tracer_cell         <= prog_head;
                            acc_reg                <= prog_acc1;
                            k_reg                  <= 4'd1;
                            state_reg              <= ST_PROG;
                        end
                    end

                    ST_PROG: begin
                        // A frame that starts before programming finishes is
                        // not restarted. It is flagged and programming goes on.
                        if (sof) begin
                            overrun <= 1'b1;
                        end
                        if (k_reg == count_reg) begin
                            wr_tracer_cell_wstrobe <= 1'b0;
                            tracer_enable          <= enable_mask;
                            frames_done            <= frames_done + 32'd1;
                            state_reg              <= ST_RUN;
                        end else begin
                            wr_tracer_cell_wstrobe <= 1'b1;
                            tracer_index           <= k_reg[2:0];
                            wr_tracer_cell         <= acc_reg;
                            acc_reg                <= acc_next;
                            k_reg                  <= k_reg + 4'd1;
                        end
                    end

                    ST_RUN: begin
                        if (sof) begin
                            if (run_complete) begin
                                tracer_enable <= 8'd0;
                                busy          <= 1'b0;
                                state_reg     <= ST_IDLE;
`ifdef TRACE_SWEEP_IRQ_EN
                                done_irq      <= 1'b1;
`endif
                            end else begin
                                // Tracers stay disabled while they are being moved.
                                head_reg               <= next_head;
                                tracer_enable          <= 8'd0;
                                wr_tracer_cell_wstrobe <= 1'b1;
                                tracer_index           <= 3'd0;
                                wr_tracer_cell         <= prog_head;
                                acc_reg                <= prog_acc1;
                                k_reg                  <= 4'd1;
                                state_reg              <= ST_PROG;
                            end
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
